// File: rtl/vga_timing_monitor.sv
// Measures incoming sync timing, declares lock once a frame repeats exactly, and emits
// the registered pixel with its active-area coordinates plus a one-shot probe capture.
module vga_timing_monitor #(
    parameter int C_H_SYNC_PULSE  = 44,
    parameter int C_H_BACK_PORCH  = 148,
    parameter int C_H_ACTIVE_TIME = 1920,
    parameter int C_V_SYNC_PULSE  = 5,
    parameter int C_V_BACK_PORCH  = 36,
    parameter int C_V_ACTIVE_TIME = 1080,
    parameter int C_PROBE_X       = 10,
    parameter int C_PROBE_Y       = 200
) (
    input  logic        I_clk_148M,
    input  logic        I_rst_n,
    input  logic        I_hs,
    input  logic        I_vs,
    input  logic [4:0]  I_red,
    input  logic [5:0]  I_green,
    input  logic [4:0]  I_blue,
    output logic [11:0] O_h_total,
    output logic [11:0] O_h_sync,
    output logic [11:0] O_v_total,
    output logic [11:0] O_v_sync,
    output logic        O_locked,
    output logic        O_active,
    output logic [11:0] O_x,
    output logic [11:0] O_y,
    output logic [15:0] O_rgb,
    output logic [15:0] O_probe_rgb,
    output logic        O_probe_valid
);
    localparam logic [12:0] X_LO    = 13'(C_H_SYNC_PULSE + C_H_BACK_PORCH);
    localparam logic [12:0] X_HI    = 13'(C_H_SYNC_PULSE + C_H_BACK_PORCH + C_H_ACTIVE_TIME);
    localparam logic [11:0] Y_LO    = 12'(C_V_SYNC_PULSE + C_V_BACK_PORCH);
    localparam logic [12:0] Y_HI    = 13'(C_V_SYNC_PULSE + C_V_BACK_PORCH + C_V_ACTIVE_TIME);
    localparam logic [11:0] PX      = 12'(C_PROBE_X);
    localparam logic [11:0] PY      = 12'(C_PROBE_Y);
    localparam logic [11:0] CNT_MAX = 12'hFFF;

    logic        hs_q, hs_d, vs_q, vs_d, h_seen_q, h_seen_d, v_seen_q, v_seen_d;
    logic        mism_q, mism_d, locked_q, locked_d, active_q, active_d;
    logic        hit_q, hit_d, probe_valid_q, probe_valid_d, probe_done_q, probe_done_d;
    logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [11:0] h_total_q, h_total_d, h_sync_q, h_sync_d, v_total_q, v_total_d, v_sync_q, v_sync_d;
    logic [11:0] st_h_total_q, st_h_total_d, st_h_sync_q, st_h_sync_d;
    logic [11:0] st_v_total_q, st_v_total_d, st_v_sync_q, st_v_sync_d;
    logic [11:0] x_q, x_d, y_q, y_d;
    logic [1:0]  match_q, match_d;
    logic [15:0] rgb_q, rgb_d, probe_rgb_q, probe_rgb_d;

    logic        hs_fall, hs_rise, v_edge, v_rise, timeout, h_line_mis, in_win, hit;
    logic [11:0] h_meas, v_meas, line;
    logic [12:0] pix;

    assign hs_fall = hs_q & ~I_hs;
    assign hs_rise = ~hs_q & I_hs;
    assign v_edge  = hs_fall & vs_q & ~I_vs;
    assign v_rise  = hs_fall & ~vs_q & I_vs;
    assign timeout = (h_cnt_q == CNT_MAX);
    assign h_meas  = h_cnt_q + 12'd1;
    assign v_meas  = v_cnt_q + 12'd1;
    // Index of the pixel sampled on this edge: a new line starts on the hs-fall itself.
    assign pix     = hs_fall ? 13'd0 : {1'b0, h_cnt_q} + 13'd1;
    assign line    = hs_fall ? (v_edge ? 12'd0 : v_meas) : v_cnt_q;

    always_comb begin
        hs_d = I_hs;           vs_d = vs_q;
        h_seen_d = h_seen_q;   v_seen_d = v_seen_q;
        mism_d = mism_q;       match_d = match_q;
        h_cnt_d = hs_fall ? 12'd0 : (timeout ? h_cnt_q : h_meas);
        v_cnt_d = v_cnt_q;
        h_total_d = h_total_q; h_sync_d = h_sync_q;
        v_total_d = v_total_q; v_sync_d = v_sync_q;
        st_h_total_d = st_h_total_q; st_h_sync_d = st_h_sync_q;
        st_v_total_d = st_v_total_q; st_v_sync_d = st_v_sync_q;
        probe_done_d = probe_done_q; probe_rgb_d = probe_rgb_q;
        h_line_mis = 1'b0;

        if (hs_fall) begin
            vs_d     = I_vs;
            h_seen_d = 1'b1;
            if (h_seen_q) begin
                h_total_d  = h_meas;
                h_line_mis = (h_meas != h_total_q);
            end
            if (v_edge) begin
                v_cnt_d  = 12'd0;
                v_seen_d = 1'b1;
                if (v_seen_q) v_total_d = v_meas;
            end else begin
                v_cnt_d = v_meas;
            end
            if (v_rise) v_sync_d = v_meas;
        end
        if (hs_rise) h_sync_d = h_meas;

        if (h_line_mis) begin
            match_d = 2'd0;
            mism_d  = 1'b1;
        end
        // Frame boundary: compare against the snapshot taken at the previous v-edge.
        if (v_edge) begin
            if (!mism_d && {h_total_d, h_sync_d, v_total_d, v_sync_d} ==
                           {st_h_total_q, st_h_sync_q, st_v_total_q, st_v_sync_q})
                match_d = (match_q == 2'd2) ? 2'd2 : match_q + 2'd1;
            else
                match_d = 2'd0;
            st_h_total_d = h_total_d; st_h_sync_d = h_sync_d;
            st_v_total_d = v_total_d; st_v_sync_d = v_sync_d;
            mism_d       = 1'b0;
            probe_done_d = 1'b0;
        end

        if (timeout) begin
            match_d   = 2'd0;
            h_total_d = 12'd0; h_sync_d = 12'd0;
            v_total_d = 12'd0; v_sync_d = 12'd0;
            h_seen_d  = hs_fall;
            v_seen_d  = v_edge;
        end
        locked_d = (match_d == 2'd2);

        in_win   = (pix >= X_LO) && (pix < X_HI) && (line >= Y_LO) && ({1'b0, line} < Y_HI);
        active_d = locked_d & in_win;
        x_d      = active_d ? pix[11:0] - X_LO[11:0] : 12'd0;
        y_d      = active_d ? line - Y_LO : 12'd0;
        rgb_d    = {I_red, I_green, I_blue};

        hit = active_d && (x_d == PX) && (y_d == PY) && !probe_done_d;
        if (hit) begin
            probe_rgb_d  = rgb_d;
            probe_done_d = 1'b1;
        end
        hit_d         = hit;
        probe_valid_d = hit_q;
    end

    always_ff @(posedge I_clk_148M or negedge I_rst_n) begin
        if (!I_rst_n) begin
            hs_q <= 1'b1;          vs_q <= 1'b1;
            h_seen_q <= 1'b0;      v_seen_q <= 1'b0;
            mism_q <= 1'b0;        match_q <= 2'd0;      locked_q <= 1'b0;
            h_cnt_q <= 12'd0;      v_cnt_q <= 12'd0;
            h_total_q <= 12'd0;    h_sync_q <= 12'd0;
            v_total_q <= 12'd0;    v_sync_q <= 12'd0;
            st_h_total_q <= 12'd0; st_h_sync_q <= 12'd0;
            st_v_total_q <= 12'd0; st_v_sync_q <= 12'd0;
            active_q <= 1'b0;      x_q <= 12'd0;         y_q <= 12'd0;
            rgb_q <= 16'd0;        probe_rgb_q <= 16'd0;
            hit_q <= 1'b0;         probe_valid_q <= 1'b0; probe_done_q <= 1'b0;
        end else begin
            hs_q <= hs_d;                 vs_q <= vs_d;
            h_seen_q <= h_seen_d;         v_seen_q <= v_seen_d;
            mism_q <= mism_d;             match_q <= match_d;   locked_q <= locked_d;
            h_cnt_q <= h_cnt_d;           v_cnt_q <= v_cnt_d;
            h_total_q <= h_total_d;       h_sync_q <= h_sync_d;
            v_total_q <= v_total_d;       v_sync_q <= v_sync_d;
            st_h_total_q <= st_h_total_d; st_h_sync_q <= st_h_sync_d;
            st_v_total_q <= st_v_total_d; st_v_sync_q <= st_v_sync_d;
            active_q <= active_d;         x_q <= x_d;           y_q <= y_d;
            rgb_q <= rgb_d;               probe_rgb_q <= probe_rgb_d;
            hit_q <= hit_d;               probe_valid_q <= probe_valid_d;
            probe_done_q <= probe_done_d;
        end
    end

    assign O_h_total     = h_total_q;
    assign O_h_sync      = h_sync_q;
    assign O_v_total     = v_total_q;
    assign O_v_sync      = v_sync_q;
    assign O_locked      = locked_q;
    assign O_active      = active_q;
    assign O_x           = x_q;
    assign O_y           = y_q;
    assign O_rgb         = rgb_q;
    assign O_probe_rgb   = probe_rgb_q;
    assign O_probe_valid = probe_valid_q;
endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor using scaled-down timing (80-clock lines, 20-line frames)
// so lock, mismatch, timeout and reset recovery fit in a short run.
module tb_vga_timing_monitor;
    localparam int HS = 8, HBP = 12, HA = 40, HT = 80;
    localparam int VS = 2, VBP = 3, VA = 10, VT = 20;
    localparam int PXR = 10, PYR = 5;
    localparam int X0 = HS + HBP, Y0 = VS + VBP;
    localparam int W = 41;

    logic        clk, rst_n, hs, vs;
    logic [4:0]  red, blue;
    logic [5:0]  green;
    logic [11:0] O_h_total, O_h_sync, O_v_total, O_v_sync, O_x, O_y;
    logic        O_locked, O_active, O_probe_valid;
    logic [15:0] O_rgb, O_probe_rgb;

    logic [W-1:0] exp_q[$];
    int  total = 0, bad = 0, probe_cnt = 0, base;
    bit  sb_on = 0, exp_locked = 0;

    vga_timing_monitor #(
        .C_H_SYNC_PULSE(HS), .C_H_BACK_PORCH(HBP), .C_H_ACTIVE_TIME(HA),
        .C_V_SYNC_PULSE(VS), .C_V_BACK_PORCH(VBP), .C_V_ACTIVE_TIME(VA),
        .C_PROBE_X(PXR), .C_PROBE_Y(PYR)
    ) dut (
        .I_clk_148M(clk), .I_rst_n(rst_n), .I_hs(hs), .I_vs(vs),
        .I_red(red), .I_green(green), .I_blue(blue),
        .O_h_total(O_h_total), .O_h_sync(O_h_sync), .O_v_total(O_v_total),
        .O_v_sync(O_v_sync), .O_locked(O_locked), .O_active(O_active),
        .O_x(O_x), .O_y(O_y), .O_rgb(O_rgb), .O_probe_rgb(O_probe_rgb),
        .O_probe_valid(O_probe_valid)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (O_probe_valid) probe_cnt++;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk12(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        check(tag, {29'd0, obs}, {29'd0, exp});
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        check(tag, {40'd0, obs}, {40'd0, exp});
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        check(tag, {25'd0, obs}, {25'd0, exp});
    endtask

    task automatic check_all_zero(input string tag);
        chk12({tag, "_h_total"}, O_h_total, 12'd0);
        chk12({tag, "_h_sync"}, O_h_sync, 12'd0);
        chk12({tag, "_v_total"}, O_v_total, 12'd0);
        chk12({tag, "_v_sync"}, O_v_sync, 12'd0);
        chk1({tag, "_locked"}, O_locked, 1'b0);
        chk1({tag, "_active"}, O_active, 1'b0);
        chk12({tag, "_x"}, O_x, 12'd0);
        chk12({tag, "_y"}, O_y, 12'd0);
        chk16({tag, "_rgb"}, O_rgb, 16'd0);
        chk16({tag, "_probe_rgb"}, O_probe_rgb, 16'd0);
        chk1({tag, "_probe_valid"}, O_probe_valid, 1'b0);
    endtask

    // driver: one clock per call; the previous pixel's expectation is checked first
    task automatic drive_clk(input logic h, input logic v, input int p, input int l);
        logic [15:0]  pixv;
        logic [W-1:0] e;
        bit           win;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pixel", {O_active, O_x, O_y, O_rgb}, e);
        end
        pixv = (p == X0 + PXR && l == Y0 + PYR) ? 16'hF800 : 16'($urandom_range(0, 65535));
        hs = h;
        vs = v;
        {red, green, blue} = pixv;
        if (sb_on) begin
            win = exp_locked && p >= X0 && p < X0 + HA && l >= Y0 && l < Y0 + VA;
            e = win ? {1'b1, 12'(p - X0), 12'(l - Y0), pixv} : {1'b0, 24'd0, pixv};
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_line(input int l, input int i0, input int i1);
        for (int i = i0; i < i1; i++) drive_clk((i < HS) ? 1'b0 : 1'b1, (l < VS) ? 1'b0 : 1'b1, i, l);
    endtask

    task automatic drive_lines(input int l0, input int l1, input int long_line);
        for (int l = l0; l <= l1; l++) drive_line(l, 0, (l == long_line) ? HT + 1 : HT);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; hs = 1'b1; vs = 1'b1; {red, green, blue} = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // frame 1: first hs-fall must not update h_total
        drive_line(0, 0, HT); settle();
        chk12("h_total_first_fall", O_h_total, 12'd0);
        chk12("h_sync_first_line", O_h_sync, 12'(HS));
        chk12("v_total_first_edge", O_v_total, 12'd0);
        drive_line(1, 0, 1); settle();
        chk12("h_total_second_fall", O_h_total, 12'(HT));
        drive_line(1, 1, HT);
        drive_lines(2, VT - 1, -1);

        // frame 2
        drive_line(0, 0, HT); settle();
        chk12("v_total_second_edge", O_v_total, 12'(VT));
        chk12("v_sync", O_v_sync, 12'(VS));
        chk1("locked_edge2", O_locked, 1'b0);
        drive_lines(1, VT - 1, -1);

        // frame 3
        drive_line(0, 0, HT); settle();
        chk1("locked_edge3", O_locked, 1'b0);
        drive_lines(1, VT - 1, -1);

        // frame 4: locked, full pixel scoreboard, probe
        exp_locked = 1; sb_on = 1; base = probe_cnt;
        drive_line(0, 0, HT); settle();
        chk1("locked_edge4", O_locked, 1'b1);
        chk12("nom_h_total", O_h_total, 12'(HT));
        chk12("nom_h_sync", O_h_sync, 12'(HS));
        chk12("nom_v_total", O_v_total, 12'(VT));
        chk12("nom_v_sync", O_v_sync, 12'(VS));
        drive_lines(1, VT - 1, -1); settle();
        chk12("probe_pulses_f4", 12'(probe_cnt - base), 12'd1);
        chk16("probe_rgb", O_probe_rgb, 16'hF800);

        // frame 5: line 7 one clock long
        base = probe_cnt;
        drive_lines(0, 7, 7); settle();
        chk1("locked_before_long", O_locked, 1'b1);
        exp_locked = 0;
        drive_line(8, 0, 1); settle();
        chk1("locked_on_long_fall", O_locked, 1'b0);
        chk12("h_total_long", O_h_total, 12'(HT + 1));
        drive_line(8, 1, HT);
        drive_lines(9, VT - 1, -1); settle();
        chk12("probe_pulses_unlocked", 12'(probe_cnt - base), 12'd0);

        // frames 6..8: relock after two clean frames
        drive_lines(0, VT - 1, -1);
        drive_line(0, 0, HT); settle();
        chk1("relock_edge7", O_locked, 1'b0);
        drive_lines(1, VT - 1, -1);
        exp_locked = 1;
        drive_line(0, 0, HT); settle();
        chk1("relock_edge8", O_locked, 1'b1);
        drive_lines(1, VT - 1, -1);
        sb_on = 0;

        // timeout: hs held high
        for (int i = 0; i < 5000; i++) drive_clk(1'b1, 1'b1, 0, 0);
        settle();
        chk12("to_h_total", O_h_total, 12'd0);
        chk12("to_h_sync", O_h_sync, 12'd0);
        chk12("to_v_total", O_v_total, 12'd0);
        chk12("to_v_sync", O_v_sync, 12'd0);
        chk1("to_locked", O_locked, 1'b0);

        // frames 9..12: recovery
        drive_line(0, 0, HT); settle();
        chk12("rec_h_total_first", O_h_total, 12'd0);
        drive_line(1, 0, 1); settle();
        chk12("rec_h_total_second", O_h_total, 12'(HT));
        drive_line(1, 1, HT);
        drive_lines(2, VT - 1, -1);
        drive_line(0, 0, HT); settle();
        chk12("rec_v_total", O_v_total, 12'(VT));
        chk1("rec_locked_e10", O_locked, 1'b0);
        drive_lines(1, VT - 1, -1);
        drive_line(0, 0, HT); settle();
        chk1("rec_locked_e11", O_locked, 1'b0);
        drive_lines(1, VT - 1, -1);
        drive_line(0, 0, HT); settle();
        chk1("rec_locked_e12", O_locked, 1'b1);
        chk12("rec_h_sync", O_h_sync, 12'(HS));
        chk12("rec_v_sync", O_v_sync, 12'(VS));
        drive_lines(1, VT - 1, -1);

        // frame 13: reset pulsed mid-line
        drive_lines(0, 11, -1);
        drive_line(12, 0, 40);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        drive_line(12, 40, HT); settle();
        check_all_zero("rst_hold");
        rst_n = 1'b1;
        drive_line(13, 0, 1); settle();
        chk12("post_rst_first_fall", O_h_total, 12'd0);
        drive_line(13, 1, HT);
        drive_line(14, 0, 1); settle();
        chk12("post_rst_second_fall", O_h_total, 12'(HT));
        drive_line(14, 1, HT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
